// File: rtl/div_pkg.sv
// Shared types and widths for the sequential 6-by-2-bit restoring divider.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 6;
    localparam int unsigned DIVISOR_W  = 2;
    localparam int unsigned CNT_W      = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    localparam int unsigned RemW = DIVISOR_W + 1;

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] div_ext;
    logic                 fits;

    always_comb begin
        shifted = {rem_in, bit_in};
        div_ext = {2'b00, divisor};
        // Compare before subtracting so the difference can never wrap.
        fits    = (shifted >= div_ext);
        q_bit   = fits;
        rem_out = RemW'(fits ? (shifted - div_ext) : shifted);
    end

endmodule

// File: rtl/seq_divider_6_by_2bit.sv
// Sequential restoring divider: 6-bit dividend / 2-bit divisor, one quotient bit per cycle,
// with a start/busy/done handshake and a divide-by-zero flag.
module seq_divider_6_by_2bit
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] q,
    output logic [DIVISOR_W-1:0]  r,
    output logic                  div_zero
);

    state_e                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DIVIDEND_W-1:0] q_q;
    logic [DIVISOR_W-1:0]  r_q;
    logic                  div_zero_q;
    logic                  zero_pend_q;

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    logic [DIVIDEND_W-1:0] shift_q;
    logic [DIVISOR_W:0]    rem_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DIVISOR_W:0]    rem_next;
    logic                  q_bit;
    logic [DIVIDEND_W-1:0] shift_next;

    div_step u_div_step (
        .rem_in  (rem_q),
        .bit_in  (shift_q[DIVIDEND_W-1]),
        .divisor (dvs_q),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign shift_next = {shift_q[DIVIDEND_W-2:0], q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            div_zero_q  <= 1'b0;
            zero_pend_q <= 1'b0;
            shift_q     <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (divisor != '0) begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            shift_q <= dividend;
                            dvs_q   <= divisor;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            state_q     <= StDone;
                            zero_pend_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    shift_q <= shift_next;
                    rem_q   <= rem_next;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                        state_q    <= StDone;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        q_q        <= shift_next;
                        r_q        <= rem_next[DIVISOR_W-1:0];
                        div_zero_q <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    // Divide-by-zero takes one cycle, so its result lands a cycle after accept.
                    if (zero_pend_q) begin
                        zero_pend_q <= 1'b0;
                        done_q      <= 1'b1;
                        q_q         <= '1;
                        r_q         <= '0;
                        div_zero_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = div_zero_q;

endmodule
